hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives write-enable and flush for PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three events: load-use stall, taken-branch flush, and multi-cycle data-memory wait with timeout.
- Sits beside the decode stage; consumes ID/EX/MEM stage fields, produces per-cycle register controls.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- TMO_W, 8, width of memory-wait timeout counter.
- MEM_TIMEOUT, 200, wait cycles before MemTimeout is flagged; must be < 2^TMO_W.

Ports:
- Clk  in  1  core clock; all state changes on posedge.
- Rst  in  1  asynchronous, active-high reset.
- RsAddr_ID  in  REG_ADDR_W  rs field of instruction in ID.
- RtAddr_ID  in  REG_ADDR_W  rt field of instruction in ID.
- UsesRt_ID  in  1  ID instruction reads rt (R-type, beq, sw).
- MemRead_EX  in  1  EX-stage instruction is a load.
- WriteRegAddress_EX  in  REG_ADDR_W  destination of EX-stage instruction.
- BranchTaken_EX  in  1  branch resolved taken in EX.
- MemReq_MEM  in  1  MEM stage issues a data-memory access.
- MemReady  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC register enable.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  IF/ID load NOP.
- IDEX_Write  out  1  ID/EX register enable.
- IDEX_Flush  out  1  ID/EX control fields loaded as zero (bubble).
- EXMEM_Write  out  1  EX/MEM register enable.
- MemTimeout  out  1  sticky error flag.
- StallCount  out  16  stall-cycle count (optional feature).
- FlushCount  out  16  flush-event count (optional feature).

Behaviour:
- Rst asserted (async): state=RUN, MemTimeout=0, wait counter=0, stats=0. While Rst is high, all *_Write=0 and both *_Flush=1.
- Outputs are combinational from the current state and current inputs. They act in the same cycle as the event.
- Default (RUN, no event): all *_Write=1, all *_Flush=0.
- States: RUN, LU_STALL, BR_SHADOW, MEM_WAIT.
- Event priority in RUN: mem-wait > branch > load-use.
- Mem-wait:
  - Trigger: MemReq_MEM && !MemReady.
  - All *_Write=0, no flush. Next state MEM_WAIT, counter=1.
- MEM_WAIT:
  - Hold freeze each cycle.
  - When MemReady=1: release that cycle with default outputs, counter=0, next state RUN. Branch and load-use are evaluated in the release cycle as in RUN.
  - When counter reaches MEM_TIMEOUT: MemTimeout=1 (sticky until Rst). Keep waiting; the counter saturates.
- Branch:
  - Trigger: BranchTaken_EX=1.
  - PCWrite=1 (loads target), IFID_Flush=1, IDEX_Flush=1. Next state BR_SHADOW.
- BR_SHADOW:
  - One cycle. BranchTaken_EX and load-use are ignored because EX holds a bubble.
  - Mem-wait is still honoured. Next state RUN.
- Load-use:
  - Trigger: MemRead_EX && WriteRegAddress_EX!=0 && (WriteRegAddress_EX==RsAddr_ID || (UsesRt_ID && WriteRegAddress_EX==RtAddr_ID)).
  - PCWrite=0, IFID_Write=0, IDEX_Flush=1. Next state LU_STALL.
- LU_STALL:
  - One cycle. Load-use detection is suppressed; branch and mem-wait are honoured.
  - Next state RUN, or MEM_WAIT/BR_SHADOW per event.
- Simultaneous events:
  - Branch together with load-use: branch wins; the ID instruction is flushed anyway.
  - Mem-wait together with any other event: freeze wins; the other event is re-evaluated on release.
- Register $0 never causes a stall.

Optional Feature:
- HAZARD_STATS_EN defined:
  - StallCount increments each cycle any of PCWrite/IFID_Write is 0 (Rst excluded).
  - FlushCount increments per cycle with IDEX_Flush=1.
  - Both are 16-bit, saturating at 16'hFFFF.
- Undefined: both ports are driven constant 0, and no counter flops exist.

Decomposition:
- Shared package: state encoding constants (RUN=2'd0, LU_STALL=2'd1, BR_SHADOW=2'd2, MEM_WAIT=2'd3) and the REG_ADDR_W default, shared with the forwarding unit.
- One sub-module: hazard_detect_lu. It holds the pure combinational load-use compare, reused by the forwarding unit.

Test Plan:
- lw $8 in EX (MemRead_EX=1, WriteRegAddress_EX=8); ID add rs=8 -> one cycle PCWrite=0, IFID_Write=0, IDEX_Flush=1, then default outputs.
- Same load with WriteRegAddress_EX=0 and RsAddr_ID=0 -> no stall.
- BranchTaken_EX=1 while a load-use is also true -> IFID_Flush=IDEX_Flush=1, PCWrite=1; next cycle BranchTaken_EX=1 is ignored.
- MemReq_MEM=1, MemReady=0 for 5 cycles, then 1 -> 5 cycles all *_Write=0, release on cycle 6.
- MemReady held 0 for MEM_TIMEOUT cycles -> MemTimeout=1 at cycle 200. It stays 1 after MemReady, clears only on Rst.
- Rst pulsed mid-MEM_WAIT (not clock-aligned) -> state RUN and flush outputs immediately. With HAZARD_STATS_EN, counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// hazard_ctrl_pkg : controller state encoding and shared register-address width
// Rev 1.0
//------------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_STALL  = 2'd1,
    BR_SHADOW = 2'd2,
    MEM_WAIT  = 2'd3
  } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// hazard_ctrl_if : pipeline stage fields in, per-cycle register controls out
// Rev 1.0
//------------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = hazard_ctrl_pkg::DEF_REG_ADDR_W
);
  import hazard_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] RsAddr_ID;
  logic [REG_ADDR_W-1:0] RtAddr_ID;
  logic                  UsesRt_ID;
  logic                  MemRead_EX;
  logic [REG_ADDR_W-1:0] WriteRegAddress_EX;
  logic                  BranchTaken_EX;
  logic                  MemReq_MEM;
  logic                  MemReady;

  logic                  PCWrite;
  logic                  IFID_Write;
  logic                  IFID_Flush;
  logic                  IDEX_Write;
  logic                  IDEX_Flush;
  logic                  EXMEM_Write;
  logic                  MemTimeout;
  logic [15:0]           StallCount;
  logic [15:0]           FlushCount;

  modport master (
    output RsAddr_ID, RtAddr_ID, UsesRt_ID, MemRead_EX, WriteRegAddress_EX,
           BranchTaken_EX, MemReq_MEM, MemReady,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, MemTimeout, StallCount, FlushCount
  );

  modport slave (
    input  RsAddr_ID, RtAddr_ID, UsesRt_ID, MemRead_EX, WriteRegAddress_EX,
           BranchTaken_EX, MemReq_MEM, MemReady,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, MemTimeout, StallCount, FlushCount
  );

endinterface
`default_nettype wire

// File: rtl/hazard_detect_lu.sv
`default_nettype none
//------------------------------------------------------------------------------
// hazard_detect_lu : combinational load-use compare (EX load vs ID sources)
// Rev 1.0
//------------------------------------------------------------------------------
module hazard_detect_lu
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic                  uses_rt,
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  load_use
);

  // $0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use = mem_read && (ex_dest != '0) &&
                    ((ex_dest == rs_addr) || (uses_rt && (ex_dest == rt_addr)));

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// hazard_ctrl : PC/IF-ID/ID-EX/EX-MEM sequencing; define HAZARD_STATS_EN for counters
// Rev 1.0
//------------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input logic         Clk,
  input logic         Rst,
  hazard_ctrl_if.slave hif
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  hz_state_t        state;
  hz_state_t        next_state;
  logic [TMO_W-1:0] wait_cnt;
  logic [TMO_W-1:0] wait_cnt_next;
  logic             mem_timeout;
  logic             load_use;
  logic             mem_hold;
  logic             branch_ok;
  logic             lu_ok;

  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;

  hazard_detect_lu #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu (
    .rs_addr  (hif.RsAddr_ID),
    .rt_addr  (hif.RtAddr_ID),
    .uses_rt  (hif.UsesRt_ID),
    .mem_read (hif.MemRead_EX),
    .ex_dest  (hif.WriteRegAddress_EX),
    .load_use (load_use)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      if (wait_cnt_next == TMO_LIMIT)
        mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_write    = 1'b1;
    idex_flush    = 1'b0;
    exmem_write   = 1'b1;
    next_state    = RUN;
    wait_cnt_next = '0;

    // Once waiting, only MemReady matters; the release cycle then behaves like RUN
    mem_hold  = (state == MEM_WAIT) ? !hif.MemReady : (hif.MemReq_MEM && !hif.MemReady);
    branch_ok = (state != BR_SHADOW);
    lu_ok     = (state == RUN) || (state == MEM_WAIT);

    if (mem_hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      next_state  = MEM_WAIT;
      if (state == MEM_WAIT)
        wait_cnt_next = (wait_cnt == TMO_LIMIT) ? wait_cnt : wait_cnt + TMO_ONE;
      else
        wait_cnt_next = TMO_ONE;
    end else if (branch_ok && hif.BranchTaken_EX) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      next_state = BR_SHADOW;
    end else if (lu_ok && load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      next_state = LU_STALL;
    end

    if (Rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end
  end

  assign hif.PCWrite     = pc_write;
  assign hif.IFID_Write  = ifid_write;
  assign hif.IFID_Flush  = ifid_flush;
  assign hif.IDEX_Write  = idex_write;
  assign hif.IDEX_Flush  = idex_flush;
  assign hif.EXMEM_Write = exmem_write;
  assign hif.MemTimeout  = mem_timeout;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((!pc_write || !ifid_write) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (idex_flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign hif.StallCount = stall_cnt;
  assign hif.FlushCount = flush_cnt;
`else
  assign hif.StallCount = 16'd0;
  assign hif.FlushCount = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_hazard_ctrl : vector table, corner sequences and random traffic vs a model
// Rev 1.0
//------------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int RW          = 5;
  localparam int MEM_TIMEOUT = 200;

  localparam logic [5:0] C_DEF = 6'b110101;
  localparam logic [5:0] C_FRZ = 6'b000000;
  localparam logic [5:0] C_BR  = 6'b111111;
  localparam logic [5:0] C_LU  = 6'b000111;
  localparam logic [5:0] C_RST = 6'b001010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(RW)) hif ();

  hazard_ctrl #(
    .REG_ADDR_W  (RW),
    .TMO_W       (8),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .hif (hif.slave)
  );

  typedef struct {
    logic [RW-1:0] rs, rt, wr;
    logic          uses_rt, mem_read, br, mreq, mrdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [5:0] exp;
  } vec_t;

  // What the previous cycle did decides which events are visible now
  typedef enum int {EV_NONE, EV_FREEZE, EV_BRANCH, EV_LU} ev_e;

  ev_e        prev_ev;
  int         run_len;
  bit         m_timeout;
  int         m_stall, m_flush;
  int         total_cnt = 0;
  int         pass_cnt  = 0;
  logic [5:0] last_ctl;
  vec_t       tbl[16];
  in_t        idle, frz, rel, r;

  function automatic in_t mk(input int rs, input int rt, input bit uses_rt, input bit mem_read,
                             input int wr, input bit br, input bit mreq, input bit mrdy);
    in_t t;
    t.rs = RW'(rs); t.rt = RW'(rt); t.wr = RW'(wr);
    t.uses_rt = uses_rt; t.mem_read = mem_read; t.br = br; t.mreq = mreq; t.mrdy = mrdy;
    return t;
  endfunction

  function automatic ev_e classify(input in_t i, input ev_e prev);
    bit dep, freeze;
    dep    = i.mem_read && (i.wr != 0) && ((i.wr == i.rs) || (i.uses_rt && (i.wr == i.rt)));
    freeze = (prev == EV_FREEZE) ? !i.mrdy : (i.mreq && !i.mrdy);
    if (freeze) return EV_FREEZE;
    if (i.br && prev != EV_BRANCH) return EV_BRANCH;
    if (dep && (prev == EV_NONE || prev == EV_FREEZE)) return EV_LU;
    return EV_NONE;
  endfunction

  function automatic logic [5:0] ctl_of(input ev_e ev);
    case (ev)
      EV_FREEZE: return C_FRZ;
      EV_BRANCH: return C_BR;
      EV_LU:     return C_LU;
      default:   return C_DEF;
    endcase
  endfunction

  function automatic logic [5:0] ctl_now();
    return {hif.PCWrite, hif.IFID_Write, hif.IFID_Flush,
            hif.IDEX_Write, hif.IDEX_Flush, hif.EXMEM_Write};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    prev_ev = EV_NONE; run_len = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  task automatic drive(input in_t i);
    hif.RsAddr_ID = i.rs;  hif.RtAddr_ID = i.rt;  hif.UsesRt_ID = i.uses_rt;
    hif.MemRead_EX = i.mem_read;  hif.WriteRegAddress_EX = i.wr;
    hif.BranchTaken_EX = i.br;  hif.MemReq_MEM = i.mreq;  hif.MemReady = i.mrdy;
  endtask

  // Called at posedge+1: apply, sample mid-cycle, compare, advance model, cross the edge
  task automatic run_cycle(input in_t i, input string tag);
    ev_e        ev;
    logic [5:0] exp;
    drive(i);
    #3;
    ev       = classify(i, prev_ev);
    exp      = ctl_of(ev);
    last_ctl = ctl_now();
    chk({tag, " ctl"}, 32'(last_ctl), 32'(exp));
    chk({tag, " timeout"}, 32'(hif.MemTimeout), 32'(m_timeout));
`ifdef HAZARD_STATS_EN
    chk({tag, " stall_cnt"}, 32'(hif.StallCount), 32'(m_stall));
    chk({tag, " flush_cnt"}, 32'(hif.FlushCount), 32'(m_flush));
`else
    chk({tag, " stats_off"}, {hif.StallCount, hif.FlushCount}, 32'd0);
`endif
    if (ev == EV_FREEZE) begin
      run_len++;
      if (run_len >= MEM_TIMEOUT) m_timeout = 1'b1;
    end else begin
      run_len = 0;
    end
    if ((!exp[5] || !exp[4]) && m_stall < 65535) m_stall++;
    if (exp[1] && m_flush < 65535) m_flush++;
    prev_ev = ev;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 1);
    frz  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    rel  = mk(0, 0, 0, 0, 0, 0, 1, 1);

    //             rs rt  u mr wr br mq rdy        expected
    tbl[0]  = '{mk(8, 0, 0, 1, 8, 0, 0, 1), C_LU };
    tbl[1]  = '{mk(8, 0, 0, 1, 8, 0, 0, 1), C_DEF};
    tbl[2]  = '{mk(0, 0, 0, 1, 0, 0, 0, 1), C_DEF};
    tbl[3]  = '{mk(1, 9, 0, 1, 9, 0, 0, 1), C_DEF};
    tbl[4]  = '{mk(1, 9, 1, 1, 9, 0, 0, 1), C_LU };
    tbl[5]  = '{mk(1, 9, 1, 1, 9, 1, 0, 1), C_BR };
    tbl[6]  = '{mk(8, 0, 0, 1, 8, 1, 0, 1), C_DEF};
    tbl[7]  = '{mk(8, 0, 0, 1, 8, 1, 0, 1), C_BR };
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0), C_FRZ};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0), C_FRZ};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 1, 0, 1), C_BR };
    tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 1, 1), C_DEF};
    tbl[12] = '{mk(0, 0, 0, 0, 0, 1, 1, 0), C_FRZ};
    tbl[13] = '{mk(3, 0, 0, 1, 3, 0, 0, 1), C_LU };
    tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 1, 0), C_FRZ};
    tbl[15] = '{mk(0, 0, 0, 0, 0, 0, 0, 1), C_DEF};

    // Reset state
    rst = 1'b1;
    drive(idle);
    model_reset();
    #2;
    chk("reset ctl", 32'(ctl_now()), 32'(C_RST));
    chk("reset timeout", 32'(hif.MemTimeout), 32'd0);
    chk("reset stats", {hif.StallCount, hif.FlushCount}, 32'd0);
    #11 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 16; k++) begin
      run_cycle(tbl[k].in, "vec");
      chk($sformatf("vec%0d table", k), 32'(last_ctl), 32'(tbl[k].exp));
    end

    // Five frozen cycles, release on the sixth
    for (int k = 0; k < 5; k++) begin
      run_cycle(frz, "memwait");
      chk($sformatf("memwait c%0d frozen", k + 1), 32'(last_ctl), 32'(C_FRZ));
    end
    run_cycle(rel, "memwait");
    chk("memwait release", 32'(last_ctl), 32'(C_DEF));

    for (int k = 0; k < 400; k++) begin
      r.rs       = RW'($urandom_range(0, 3));
      r.rt       = RW'($urandom_range(0, 3));
      r.wr       = RW'($urandom_range(0, 3));
      r.uses_rt  = 1'($urandom_range(0, 1));
      r.mem_read = 1'($urandom_range(0, 1));
      r.br       = ($urandom_range(0, 3) == 0);
      r.mreq     = ($urandom_range(0, 9) < 3);
      r.mrdy     = ($urandom_range(0, 9) < 6);
      run_cycle(r, "random");
    end

    // Timeout: flag appears once the wait has lasted MEM_TIMEOUT cycles
    run_cycle(idle, "pre_tmo");
    for (int k = 1; k <= MEM_TIMEOUT + 3; k++) begin
      run_cycle(frz, "tmo");
      if (k == MEM_TIMEOUT - 1) chk("timeout early", 32'(hif.MemTimeout), 32'd0);
      if (k == MEM_TIMEOUT)     chk("timeout set", 32'(hif.MemTimeout), 32'd1);
    end
    run_cycle(rel, "tmo_release");
    for (int k = 0; k < 3; k++) run_cycle(idle, "tmo_after");
    chk("timeout sticky", 32'(hif.MemTimeout), 32'd1);

    // Asynchronous reset in the middle of a wait
    run_cycle(frz, "prerst");
    run_cycle(frz, "prerst");
    drive(frz);
    #2 rst = 1'b1;
    #1;
    chk("async rst ctl", 32'(ctl_now()), 32'(C_RST));
    chk("async rst timeout", 32'(hif.MemTimeout), 32'd0);
    chk("async rst stats", {hif.StallCount, hif.FlushCount}, 32'd0);
    @(posedge clk);
    #2;
    chk("rst held ctl", 32'(ctl_now()), 32'(C_RST));
    drive(idle);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    run_cycle(frz, "post_rst");
    chk("post rst enters wait from RUN", 32'(last_ctl), 32'(C_FRZ));
    run_cycle(rel, "post_rst");
    run_cycle(idle, "post_rst");
    chk("post rst run", 32'(last_ctl), 32'(C_DEF));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
